// File: rtl/p2_pkg.sv
// Shared definitions for the pooling-2 memory: geometry of the 4x4 pooled
// feature map and the reader's FSM state encoding.
package p2_pkg;

  localparam int N_WORDS = 16;
  localparam int ADDR_W  = 4;
  localparam int DATA_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/p2_mem_read_if.sv
// Bus bundle for the pooling-2 reader: the synchronous memory read port and
// the ready/valid output stream toward the fully-connected stage.
//
// Stream handshake: a word transfers on every rising clk edge where out_valid
// and out_ready are both high. Once out_valid is raised, out_data and out_last
// hold steady until that transfer; out_ready may change freely and the
// producer never waits for out_ready before raising out_valid.
// Memory port: rd_data carries mem[addr] in the cycle after rd_en was high.
interface p2_mem_read_if #(
  parameter int ADDR_W = p2_pkg::ADDR_W,
  parameter int DATA_W = p2_pkg::DATA_W
);

  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  // Reader side.
  modport master (
    output rd_en, addr, out_data, out_valid, out_last,
    input  rd_data, out_ready
  );

  // Memory + downstream consumer side.
  modport slave (
    input  rd_en, addr, out_data, out_valid, out_last,
    output rd_data, out_ready
  );

endinterface

// File: rtl/p2_rd_skid.sv
// Two-entry FIFO between the memory read port and the output stream. It holds
// words that arrive while the consumer is stalled; the issue logic upstream
// guarantees a push never lands on a full buffer.
module p2_rd_skid #(
  parameter int DATA_W = p2_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] entry_q [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        occ_q;

  // Storage, pointers and occupancy; all cleared so a reset drops buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      if (push) begin
        entry_q[wr_ptr] <= din;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head = entry_q[rd_ptr];
  assign occ  = occ_q;

endmodule

// File: rtl/p2_mem_read.sv
// Sequential reader for the pooling-2 output memory. On start it sweeps
// addresses 0..N_WORDS-1 through the synchronous read port and streams the
// words to the FC stage, flagging the final word with out_last.
module p2_mem_read #(
  parameter int N_WORDS = p2_pkg::N_WORDS,
  parameter int ADDR_W  = p2_pkg::ADDR_W,
  parameter int DATA_W  = p2_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output p2_pkg::state_t      state_dbg,
  p2_mem_read_if.master       bus
);

  import p2_pkg::*;

  localparam logic [ADDR_W:0]   ISSUE_END    = (ADDR_W+1)'(N_WORDS);
  localparam logic [ADDR_W-1:0] OUT_LAST_IDX = ADDR_W'(N_WORDS - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W:0]   issue_idx;
  logic [ADDR_W-1:0] out_idx;
  logic              inflight;
  logic [1:0]        occ;
  logic [DATA_W-1:0] head;
  logic              out_valid;
  logic              pop;
  logic              rd_en;
  logic              start_pass;
  logic [2:0]        demand;
  logic [2:0]        limit;

  // A pass may only be launched from a quiescent state.
  assign start_pass = start && ((state == IDLE) || (state == DONE));

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && bus.out_ready;

  // Buffered plus in-flight words must stay within the 2 buffer slots; a pop
  // this cycle frees one, which is why out_ready reaches rd_en directly.
  assign demand = {1'b0, occ} + {2'b00, inflight};
  assign limit  = 3'd2 + {2'b00, pop};
  assign rd_en  = (state == READ) && (issue_idx < ISSUE_END) && (demand < limit);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    if (issue_idx == ISSUE_END) state_nx = DRAIN;
      DRAIN:   if ((occ == 2'd0) && !inflight) state_nx = DONE;
      DONE:    if (start) state_nx = READ;
      default: state_nx = IDLE;
    endcase
  end

  // Issue/output counters and the one-cycle memory latency tracker.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_idx <= '0;
      out_idx   <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (start_pass) begin
        issue_idx <= '0;
        out_idx   <= '0;
      end else begin
        if (rd_en) issue_idx <= issue_idx + 1'b1;
        if (pop)   out_idx   <= out_idx + 1'b1;
      end
    end
  end

  p2_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight),
    .din   (bus.rd_data),
    .pop   (pop),
    .head  (head),
    .occ   (occ)
  );

  assign bus.rd_en     = rd_en;
  assign bus.addr      = issue_idx[ADDR_W-1:0];
  assign bus.out_valid = out_valid;
  assign bus.out_data  = head;
  assign bus.out_last  = out_valid && (out_idx == OUT_LAST_IDX);

  assign busy      = (state == READ) || (state == DRAIN);
  assign done      = (state == DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_p2_mem_read.sv
// Directed bench for p2_mem_read: full-rate pass, toggling backpressure, long
// stall, ignored/accepted start pulses and a mid-pass reset.
module tb_p2_mem_read;

  import p2_pkg::*;

  localparam int NW = 16;

  logic   clk = 1'b0;
  logic   reset;
  logic   start;
  logic   busy;
  logic   done;
  state_t state_dbg;

  p2_mem_read_if bus ();

  p2_mem_read dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [NW];
  initial begin
    for (int i = 0; i < NW; i++) mem[i] = 16'(i * 3 + 1);
  end

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.addr];
  end

  // ---------------- monitor (samples on falling edge) ----------------
  logic [15:0] got_q[$];
  bit          last_q[$];
  int          hs_edge_q[$];
  int          rd_addr_q[$];
  int          issued, popped, max_out, max_occ, valid_cycles;

  always @(negedge clk) begin
    int rd_i, hs_i, outstanding;
    if (!reset) begin
      rd_i = bus.rd_en ? 1 : 0;
      hs_i = (bus.out_valid && bus.out_ready) ? 1 : 0;
      if (bus.rd_en) rd_addr_q.push_back(int'(bus.addr));
      if (hs_i == 1) begin
        got_q.push_back(bus.out_data);
        last_q.push_back(bus.out_last);
        hs_edge_q.push_back(cyc + 1);
      end
      outstanding = issued + rd_i - popped - hs_i;
      issued  <= issued + rd_i;
      popped  <= popped + hs_i;
      if (bus.out_valid) valid_cycles <= valid_cycles + 1;
      if (outstanding > max_out) max_out <= outstanding;
      if (int'(dut.u_skid.occ) > max_occ) max_occ <= int'(dut.u_skid.occ);
    end
  end

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    for (int i = 0; i < NW; i++) exp_q.push_back(16'(i * 3 + 1));
  end

  // ---------------- driver tasks ----------------
  task automatic clear_mon();
    got_q.delete();
    last_q.delete();
    hs_edge_q.delete();
    rd_addr_q.delete();
    issued = 0; popped = 0; max_out = 0; max_occ = 0; valid_cycles = 0;
  endtask

  // Returns k = index of the edge that sampled start.
  task automatic pulse_start(output int k);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = cyc;
  endtask

  // Returns the edge after which done was first seen, or flags a timeout.
  task automatic wait_done(output int dcyc, output bit timed_out);
    timed_out = 1'b1;
    dcyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        timed_out = 1'b0;
        dcyc = cyc;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (bus.rd_en !== 1'b0 || bus.addr !== 4'd0) begin
      n_fail++; $display("FAIL reset_rd: rd_en=%b addr=%0d want 0/0", bus.rd_en, bus.addr);
    end
    n_tests++;
    if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.out_data !== 16'd0) begin
      n_fail++; $display("FAIL reset_stream: valid=%b last=%b data=%0d want 0/0/0",
                         bus.out_valid, bus.out_last, bus.out_data);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++; $display("FAIL reset_status: busy=%b done=%b state=%0d want 0/0/IDLE",
                         busy, done, state_dbg);
    end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_stream();
    int k, d, bad;
    bit to;
    bus.out_ready = 1'b1;
    clear_mon();
    pulse_start(k);
    wait_done(d, to);
    n_tests++;
    if (to) begin n_fail++; $display("FAIL stream_timeout: done never rose"); end
    n_tests++;
    if (got_q.size() != NW) begin
      n_fail++; $display("FAIL stream_count: got %0d words want %0d", got_q.size(), NW);
    end
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stream_data: %0d words wrong want 0", bad); end
    bad = 0;
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] !== (i == NW - 1)) bad++;
    n_tests++;
    if (bad != 0 || last_q.size() != NW) begin
      n_fail++; $display("FAIL stream_last: %0d misplaced out_last want 0", bad);
    end
    n_tests++;
    if (hs_edge_q.size() == 0 || hs_edge_q[0] != k + 3 || hs_edge_q[hs_edge_q.size()-1] != k + 18) begin
      n_fail++; $display("FAIL stream_hs_edges: first/last handshake edge offsets wrong (k=%0d) want k+3/k+18", k);
    end
    n_tests++;
    if (d != k + 19) begin
      n_fail++; $display("FAIL stream_done_edge: done after edge k+%0d want k+19", d - k);
    end
    n_tests++;
    if (busy !== 1'b0 || state_dbg !== DONE) begin
      n_fail++; $display("FAIL stream_end_state: busy=%b state=%0d want 0/DONE", busy, state_dbg);
    end
  endtask

  task automatic test_toggle();
    int k, bad;
    bit to;
    bus.out_ready = 1'b1;
    clear_mon();
    pulse_start(k);
    to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1 bus.out_ready = ~bus.out_ready;
      if (done) begin to = 1'b0; break; end
    end
    bus.out_ready = 1'b1;
    n_tests++;
    if (to) begin n_fail++; $display("FAIL toggle_timeout: done never rose"); end
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_tests++;
    if (bad != 0 || got_q.size() != NW) begin
      n_fail++; $display("FAIL toggle_data: %0d wrong, %0d words want 0 wrong, %0d words", bad, got_q.size(), NW);
    end
    n_tests++;
    if (max_out > 2 || max_occ > 2) begin
      n_fail++; $display("FAIL toggle_bound: outstanding=%0d occ=%0d want both <=2", max_out, max_occ);
    end
  endtask

  task automatic test_stall();
    int k, d, bad;
    bit to;
    bus.out_ready = 1'b0;
    clear_mon();
    pulse_start(k);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 3 && !(bus.out_valid === 1'b1 && bus.out_data === 16'd1)) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL stall_hold: %0d cycles without word 1 held want 0", bad); end
    n_tests++;
    if (issued != 2 || rd_addr_q.size() != 2 || rd_addr_q[0] != 0 || rd_addr_q[1] != 1) begin
      n_fail++; $display("FAIL stall_reads: %0d reads issued want 2 (addr 0,1)", issued);
    end
    n_tests++;
    if (popped != 0 || state_dbg !== READ || busy !== 1'b1) begin
      n_fail++; $display("FAIL stall_state: popped=%0d state=%0d busy=%b want 0/READ/1", popped, state_dbg, busy);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_done(d, to);
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_tests++;
    if (to || bad != 0 || got_q.size() != NW) begin
      n_fail++; $display("FAIL stall_release: timeout=%0b %0d wrong, %0d words want 0, 0, %0d", to, bad, got_q.size(), NW);
    end
  endtask

  task automatic test_ignored_start();
    int k, d, bad;
    bit to, seen;
    bus.out_ready = 1'b1;
    clear_mon();
    pulse_start(k);
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (state_dbg == DRAIN) begin seen = 1'b1; break; end
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_tests++;
    if (!seen) begin n_fail++; $display("FAIL ign_drain: DRAIN state never observed"); end
    wait_done(d, to);
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_tests++;
    if (to || bad != 0 || got_q.size() != NW || d != k + 19) begin
      n_fail++; $display("FAIL ign_seq: timeout=%0b wrong=%0d words=%0d done=k+%0d want 0/0/%0d/k+19",
                         to, bad, got_q.size(), d - k, NW);
    end
    // start while DONE launches a second pass
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rerun_edge: done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(d, to);
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_tests++;
    if (to || bad != 0 || got_q.size() != NW) begin
      n_fail++; $display("FAIL rerun_seq: timeout=%0b wrong=%0d words=%0d want 0/0/%0d", to, bad, got_q.size(), NW);
    end
  endtask

  task automatic test_reset_mid();
    int k, d, bad;
    bit to, reached;
    bus.out_ready = 1'b1;
    clear_mon();
    pulse_start(k);
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (popped >= 5) begin reached = 1'b1; break; end
    end
    @(posedge clk); #2 reset = 1'b1;
    #1;
    n_tests++;
    if (!reached || bus.rd_en !== 1'b0 || bus.addr !== 4'd0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || bus.out_data !== 16'd0) begin
      n_fail++; $display("FAIL midreset_outputs: reached=%0b rd_en=%b addr=%0d valid=%b last=%b data=%0d want 1/0/0/0/0/0",
                         reached, bus.rd_en, bus.addr, bus.out_valid, bus.out_last, bus.out_data);
    end
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || state_dbg !== IDLE) begin
      n_fail++; $display("FAIL midreset_status: busy=%b done=%b state=%0d want 0/0/IDLE", busy, done, state_dbg);
    end
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    clear_mon();
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (valid_cycles != 0 || issued != 0) begin
      n_fail++; $display("FAIL midreset_quiet: valid_cycles=%0d reads=%0d want 0/0", valid_cycles, issued);
    end
    clear_mon();
    pulse_start(k);
    wait_done(d, to);
    bad = 0;
    for (int i = 0; i < NW; i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    n_tests++;
    if (to || bad != 0 || got_q.size() != NW || rd_addr_q.size() == 0 || rd_addr_q[0] != 0) begin
      n_fail++; $display("FAIL midreset_rerun: timeout=%0b wrong=%0d words=%0d want 0/0/%0d from addr 0",
                         to, bad, got_q.size(), NW);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_stall();
    test_ignored_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
